// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetched instruction/PC, flags fetch address errors,
// tags delay slots and keeps a saturating stall-cycle counter.
module if_id_reg #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_4FFC,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic [31:0]      InstrF,
    input  logic [31:0]      PCF,
    input  logic             IsBJD,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCD,
    output logic [31:0]      PC8D,
    output logic [4:0]       ExcCodeD,
    output logic             BDD,
    output logic             ValidD,
    output logic [CNT_W-1:0] StallCnt
);

    localparam logic [4:0] ExcNone = 5'd0;
    localparam logic [4:0] ExcAdEL = 5'd4;

    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic [4:0]       exc_q, exc_d;
    logic             bd_q, bd_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fetch_err;

    assign fetch_err = (PCF[1:0] != 2'b00) || (PCF < IM_BASE) || (PCF > IM_LIMIT);

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (FlushD) begin
            instr_d = 32'd0;
            pc_d    = PCF;
            exc_d   = ExcNone;
            bd_d    = 1'b0;
            valid_d = 1'b0;
        end else if (StallD) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pc_d    = PCF;
            bd_d    = IsBJD;
            valid_d = 1'b1;
            // A faulting fetch stays valid so the exception reaches CP0, but decodes as nop.
            if (fetch_err) begin
                exc_d   = ExcAdEL;
                instr_d = 32'd0;
            end else begin
                exc_d   = ExcNone;
                instr_d = InstrF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= 32'd0;
            pc_q    <= PC_RESET;
            exc_q   <= ExcNone;
            bd_q    <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pc_q;
    assign PC8D     = pc_q + 32'd8;
    assign ExcCodeD = exc_q;
    assign BDD      = bd_q;
    assign ValidD   = valid_q;
    assign StallCnt = cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed, table-driven bench for if_id_reg with a 4-bit stall counter.
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        reset, StallD, FlushD, IsBJD;
    logic [31:0] InstrF, PCF;
    logic [31:0] InstrD, PCD, PC8D;
    logic [4:0]  ExcCodeD;
    logic        BDD, ValidD;
    logic [3:0]  StallCnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    if_id_reg #(.CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .InstrF   (InstrF),
        .PCF      (PCF),
        .IsBJD    (IsBJD),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PC8D     (PC8D),
        .ExcCodeD (ExcCodeD),
        .BDD      (BDD),
        .ValidD   (ValidD),
        .StallCnt (StallCnt)
    );

    typedef struct {
        logic        rst, stall, flush, isbj;
        logic [31:0] pcf, instrf;
        logic [31:0] e_instr, e_pc, e_pc8;
        logic [4:0]  e_exc;
        logic        e_bd, e_valid;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic stall, logic flush, logic isbj,
                                logic [31:0] pcf, logic [31:0] instrf,
                                logic [31:0] e_instr, logic [31:0] e_pc, logic [31:0] e_pc8,
                                logic [4:0] e_exc, logic e_bd, logic e_valid, logic [3:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.isbj = isbj;
        v.pcf = pcf; v.instrf = instrf;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_pc8 = e_pc8;
        v.e_exc = e_exc; v.e_bd = e_bd; v.e_valid = e_valid; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic flush, input logic isbj,
                         input logic [31:0] pcf, input logic [31:0] instrf);
        reset = rst; StallD = stall; FlushD = flush; IsBJD = isbj; PCF = pcf; InstrF = instrf;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; StallD = 1'b0; FlushD = 1'b0; IsBJD = 1'b0;
        PCF = 32'h3000; InstrF = 32'h3C01_0001;

        //            rst stl fl bj  PCF           InstrF        eInstr        ePC           ePC8          exc bd v cnt
        vecs.push_back(mk(1, 0, 0, 0, 32'h3000,     32'h3C010001, 32'h0,        32'h3000,     32'h3008,     0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h3000,     32'h3C010001, 32'h0,        32'h3000,     32'h3008,     0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h3000,     32'h3C010001, 32'h3C010001, 32'h3000,     32'h3008,     0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h3004,     32'h8C220000, 32'h8C220000, 32'h3004,     32'h300C,     0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 32'h3008,     32'h11111111, 32'h8C220000, 32'h3004,     32'h300C,     0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 32'h300C,     32'h22222222, 32'h8C220000, 32'h3004,     32'h300C,     0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 0, 0, 32'h3002,     32'h33333333, 32'h8C220000, 32'h3004,     32'h300C,     0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 32'h3008,     32'hAABBCCDD, 32'hAABBCCDD, 32'h3008,     32'h3010,     0, 0, 1, 3));
        // flush beats stall, counter untouched
        vecs.push_back(mk(0, 1, 1, 1, 32'h3010,     32'h12345678, 32'h0,        32'h3010,     32'h3018,     0, 0, 0, 3));
        // stall on a bubble still counts
        vecs.push_back(mk(0, 1, 0, 0, 32'h3014,     32'h12345678, 32'h0,        32'h3010,     32'h3018,     0, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0, 32'h3002,     32'h12345678, 32'h0,        32'h3002,     32'h300A,     4, 0, 1, 4));
        vecs.push_back(mk(0, 0, 0, 1, 32'h5000,     32'h00000001, 32'h0,        32'h5000,     32'h5008,     4, 1, 1, 4));
        vecs.push_back(mk(0, 0, 0, 0, 32'h2FFC,     32'h00000002, 32'h0,        32'h2FFC,     32'h3004,     4, 0, 1, 4));
        vecs.push_back(mk(0, 0, 0, 0, 32'h4FFC,     32'h01234567, 32'h01234567, 32'h4FFC,     32'h5004,     0, 0, 1, 4));
        vecs.push_back(mk(0, 0, 0, 1, 32'h3020,     32'h24020001, 32'h24020001, 32'h3020,     32'h3028,     0, 1, 1, 4));
        vecs.push_back(mk(0, 0, 0, 0, 32'h3024,     32'h24030002, 32'h24030002, 32'h3024,     32'h302C,     0, 0, 1, 4));
        vecs.push_back(mk(0, 0, 0, 1, 32'h3028,     32'h24040003, 32'h24040003, 32'h3028,     32'h3030,     0, 1, 1, 4));
        // held delay-slot tag survives IsBJD dropping during stall
        vecs.push_back(mk(0, 1, 0, 0, 32'h302C,     32'h24050004, 32'h24040003, 32'h3028,     32'h3030,     0, 1, 1, 5));
        // reset mid-stall wins
        vecs.push_back(mk(1, 1, 0, 1, 32'h3030,     32'h24060005, 32'h0,        32'h3000,     32'h3008,     0, 0, 0, 0));
        // PC8D wraps without carry
        vecs.push_back(mk(0, 0, 0, 0, 32'hFFFFFFFC, 32'h24070006, 32'h0,        32'hFFFFFFFC, 32'h00000004, 4, 0, 1, 0));
        // reset mid-flush wins
        vecs.push_back(mk(1, 0, 1, 0, 32'h3040,     32'h24080007, 32'h0,        32'h3000,     32'h3008,     0, 0, 0, 0));

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.rst, v.stall, v.flush, v.isbj, v.pcf, v.instrf);
            check($sformatf("v%0d InstrD", i), InstrD, v.e_instr);
            check($sformatf("v%0d PCD", i), PCD, v.e_pc);
            check($sformatf("v%0d PC8D", i), PC8D, v.e_pc8);
            check($sformatf("v%0d ExcCodeD", i), {27'd0, ExcCodeD}, {27'd0, v.e_exc});
            check($sformatf("v%0d BDD", i), {31'd0, BDD}, {31'd0, v.e_bd});
            check($sformatf("v%0d ValidD", i), {31'd0, ValidD}, {31'd0, v.e_valid});
            check($sformatf("v%0d StallCnt", i), {28'd0, StallCnt}, {28'd0, v.e_cnt});
        end

        // Saturation: 20 stall cycles from a cleared counter, must stop at 15.
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h3000, 32'h0);
            check($sformatf("sat%0d StallCnt", i), {28'd0, StallCnt},
                  (i > 15) ? 32'd15 : i);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h3100, 32'hDEADBEEF);
        check("sat load StallCnt", {28'd0, StallCnt}, 32'd15);
        check("sat load InstrD", InstrD, 32'hDEADBEEF);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h3104, 32'h0);
        check("sat reset StallCnt", {28'd0, StallCnt}, 32'd0);
        check("sat reset ValidD", {31'd0, ValidD}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h3104, 32'h0);
        check("post reset StallCnt", {28'd0, StallCnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- IF/ID pipeline register of the 5-stage MIPS core; sits directly downstream of the PC register and instruction memory.
- Captures the fetched instruction and its PC each cycle and presents them to decode.
- Honours the hazard unit's stall and the exception/eret flush.
- Detects fetch-address exceptions (AdEL) and tags branch-delay-slot instructions.
- Keeps a saturating count of decode-stall cycles for performance debug.

Parameters:
- PC_RESET, 32'h00003000, PC value presented in PCD after reset.
- IM_BASE, 32'h00003000, lowest legal fetch address.
- IM_LIMIT, 32'h00004FFC, highest legal fetch address (inclusive).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high.
- StallD  input  1  from hazard unit; same cycle as StallF; hold register contents.
- FlushD  input  1  exception/eret flush; insert bubble.
- InstrF  input  32  instruction read from IM at PCF.
- PCF  input  32  current PC (PC register output).
- IsBJD  input  1  decode stage holds a branch/jump, so the instruction in F is its delay slot.
- InstrD  output  32  instruction to decode.
- PCD  output  32  PC of InstrD.
- PC8D  output  32  PCD+8, the link address for jal/jalr.
- ExcCodeD  output  5  0 = none, 4 = AdEL on fetch.
- BDD  output  1  InstrD is in a delay slot.
- ValidD  output  1  0 = bubble.
- StallCnt  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- All outputs are registered except PC8D, which is combinational PCD+8 with 32-bit wrap and no carry-out.
- Priority on each posedge: reset > FlushD > StallD > load.
- reset:
  - InstrD=0, PCD=PC_RESET, ExcCodeD=0, BDD=0, ValidD=0, StallCnt=0.
  - PC8D therefore reads PC_RESET+8.
- FlushD=1 (no reset):
  - InstrD=0, PCD=PCF, ExcCodeD=0, BDD=0, ValidD=0.
  - Flush wins over a simultaneous StallD.
  - StallCnt is not incremented that cycle.
- StallD=1 (no reset/flush):
  - All data outputs hold.
  - StallCnt increments by 1, saturating at 2^CNT_W-1 (no wrap).
- Load (none of the above):
  - PCD=PCF, BDD=IsBJD, ValidD=1.
  - If PCF[1:0]!=0, PCF<IM_BASE or PCF>IM_LIMIT (unsigned compares):
    - ExcCodeD=4 and InstrD=0, so the faulting slot decodes as nop but stays valid.
    - ExcCodeD and BDD carry the exception to the CP0 stage.
  - Otherwise ExcCodeD=0 and InstrD=InstrF.
- IsBJD is sampled only on load. A held instruction keeps its original BDD even if IsBJD changes during a stall.
- StallCnt:
  - Only reset clears it.
  - It counts stall cycles, including those occurring while ValidD=0.
- Reset asserted mid-stall or mid-flush: reset values on the next edge, no residue.
- Reset deasserted: the first load happens on the first edge with reset=0 and no stall/flush.
- No combinational path from any input to any output; PC8D depends only on registered PCD.

Test Plan:
- Reset → outputs: reset=1 for 2 cycles then release with PCF=0x3000, InstrF=0x3C010001 → during reset ValidD=0, PCD=0x3000, PC8D=0x3008. On the first edge after release: InstrD=0x3C010001, ValidD=1, ExcCodeD=0, PC8D=0x3008.
- Stall hold: load PCF=0x3004/InstrF=0x8C220000, then StallD=1 for 3 cycles while PCF/InstrF/IsBJD change → InstrD=0x8C220000, PCD=0x3004 and BDD constant; StallCnt goes 0→3. The next load takes the new values.
- Flush vs stall: StallD=1 and FlushD=1 together with PCF=0x3010 → InstrD=0, ValidD=0, PCD=0x3010; StallCnt unchanged.
- Fetch exceptions:
  - PCF=0x3002 → ExcCodeD=4, InstrD=0, ValidD=1.
  - PCF=0x5000 and PCF=0x2FFC → ExcCodeD=4.
  - PCF=0x4FFC → ExcCodeD=0, InstrD=InstrF.
- Delay slot: IsBJD=1 on load of PCF=0x3020 → BDD=1. Next load with IsBJD=0 → BDD=0.
- Counter saturation (CNT_W=4): hold StallD=1 for 20 cycles → StallCnt reaches 15 and stays 15. Then reset → 0.
